// File: rtl/fifo_gen_if.sv
// Handshake and status bundle for fifo_gen: master is the producer/consumer side,
// slave is the FIFO itself.
interface fifo_gen_if #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  flush;
  logic                  write;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  read;
  logic                  clear_flags;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   level;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, write, data_in, read, clear_flags,
    input  data_out, data_valid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );

  modport slave (
    input  flush, write, data_in, read, clear_flags,
    output data_out, data_valid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );
endinterface

// File: rtl/fifo_gen.sv
// Parametrised single-clock FIFO on inferred block RAM with exact level, almost flags,
// sticky error flags, synchronous flush and optional first-word-fall-through output.
module fifo_gen #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned AF_LEVEL   = (1 << ADDR_WIDTH) - 4,
  parameter int unsigned AE_LEVEL   = 4,
  parameter bit          FWFT       = 1'b0
) (
  input logic         clk,
  input logic         reset,
  fifo_gen_if.slave   bus
);

  localparam int unsigned DEPTH   = 1 << ADDR_WIDTH;
  localparam int unsigned LEVEL_W = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] ram_q;

  logic [ADDR_WIDTH-1:0] wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
  logic [LEVEL_W-1:0]    level_q, level_n;
  logic [DATA_WIDTH-1:0] dout_q, dout_n;
  logic                  q_valid, q_valid_n;
  logic                  dv_q, dv_n;
  logic                  full_q, full_n, empty_q, empty_n;
  logic                  af_q, af_n, ae_q, ae_n;
  logic                  ovf_q, ovf_n, unf_q, unf_n;

  logic                  rd_ok, wr_ok, fetch, advance;
  logic [1:0]            in_pipe;

  // RAM port: write on accepted write, registered read on fetch
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= bus.data_in;
    if (fetch) ram_q <= mem[rd_ptr];
  end

  // Next-state: acceptance, pointers, level, output pipeline and flags
  always_comb begin
    rd_ok     = 1'b0;
    wr_ok     = 1'b0;
    advance   = 1'b0;
    fetch     = 1'b0;
    in_pipe   = 2'(q_valid) + 2'(dv_q);
    wr_ptr_n  = wr_ptr;
    rd_ptr_n  = rd_ptr;
    level_n   = level_q;
    q_valid_n = q_valid;
    dv_n      = dv_q;
    dout_n    = dout_q;
    ovf_n     = ovf_q && !bus.clear_flags;
    unf_n     = unf_q && !bus.clear_flags;

    if (!bus.flush) begin
      if (FWFT) rd_ok = bus.read && dv_q;
      else      rd_ok = bus.read && (level_q != '0);
      wr_ok = bus.write && ((level_q != LEVEL_W'(DEPTH)) || rd_ok);

      // FWFT prefetches while unfetched words exist and the two-stage pipe has room
      if (FWFT) begin
        advance = q_valid && (!dv_q || rd_ok);
        fetch   = (level_q > LEVEL_W'(in_pipe)) && (!q_valid || advance);
      end else begin
        advance = q_valid;
        fetch   = rd_ok;
      end

      if (wr_ok) wr_ptr_n = wr_ptr + ADDR_WIDTH'(1);
      if (fetch) rd_ptr_n = rd_ptr + ADDR_WIDTH'(1);
      level_n = level_q + LEVEL_W'(wr_ok) - LEVEL_W'(rd_ok);

      if (fetch)        q_valid_n = 1'b1;
      else if (advance) q_valid_n = 1'b0;
      if (advance) dout_n = ram_q;

      if (FWFT) begin
        if (advance)    dv_n = 1'b1;
        else if (rd_ok) dv_n = 1'b0;
      end else begin
        dv_n = advance;
      end

      if (bus.write && !wr_ok)         ovf_n = 1'b1;
      if (bus.read && level_q == '0)   unf_n = 1'b1;
    end else begin
      wr_ptr_n  = '0;
      rd_ptr_n  = '0;
      level_n   = '0;
      q_valid_n = 1'b0;
      dv_n      = 1'b0;
    end

    full_n  = (level_n == LEVEL_W'(DEPTH));
    empty_n = FWFT ? !dv_n : (level_n == '0);
    af_n    = (level_n >= LEVEL_W'(AF_LEVEL));
    ae_n    = (level_n <= LEVEL_W'(AE_LEVEL));
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      q_valid <= 1'b0;
      dv_q    <= 1'b0;
      dout_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr_n;
      rd_ptr  <= rd_ptr_n;
      level_q <= level_n;
      q_valid <= q_valid_n;
      dv_q    <= dv_n;
      dout_q  <= dout_n;
      full_q  <= full_n;
      empty_q <= empty_n;
      af_q    <= af_n;
      ae_q    <= ae_n;
      ovf_q   <= ovf_n;
      unf_q   <= unf_n;
    end
  end

  assign bus.data_out     = dout_q;
  assign bus.data_valid   = dv_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.level        = level_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_fifo_gen.sv
// Scoreboard bench for fifo_gen: one registered-read instance and one FWFT instance.
module tb_fifo_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fifo_gen_if #(.ADDR_WIDTH(9), .DATA_WIDTH(8)) bus0 ();
  fifo_gen_if #(.ADDR_WIDTH(9), .DATA_WIDTH(8)) bus1 ();

  fifo_gen #(.ADDR_WIDTH(9), .DATA_WIDTH(8), .AF_LEVEL(510), .AE_LEVEL(4), .FWFT(1'b0))
    dut0 (.clk(clk), .reset(reset), .bus(bus0));
  fifo_gen #(.ADDR_WIDTH(9), .DATA_WIDTH(8), .FWFT(1'b1))
    dut1 (.clk(clk), .reset(reset), .bus(bus1));

  int checks = 0;
  int failures = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int  m_level;
  bit  m_ovf, m_unf;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor for registered-read instance: every valid word must be the next expected
  always @(negedge clk) begin
    if (!reset && bus0.data_valid) begin
      if (q0.size() == 0) chk("dut0_unexpected_valid", 1, 0);
      else chk("dut0_data", int'(bus0.data_out), int'(q0.pop_front()));
    end
  end

  // Monitor for FWFT instance: compare the word being popped
  always @(negedge clk) begin
    if (!reset && bus1.data_valid && bus1.read) begin
      if (q1.size() == 0) chk("dut1_unexpected_pop", 1, 0);
      else chk("dut1_data", int'(bus1.data_out), int'(q1.pop_front()));
    end
  end

  task automatic check_reset_vals();
    chk("rst_dout0", int'(bus0.data_out), 0);   chk("rst_dv0", int'(bus0.data_valid), 0);
    chk("rst_full0", int'(bus0.full), 0);       chk("rst_empty0", int'(bus0.empty), 1);
    chk("rst_af0", int'(bus0.almost_full), 0);  chk("rst_ae0", int'(bus0.almost_empty), 1);
    chk("rst_level0", int'(bus0.level), 0);     chk("rst_ovf0", int'(bus0.overflow), 0);
    chk("rst_unf0", int'(bus0.underflow), 0);
    chk("rst_dout1", int'(bus1.data_out), 0);   chk("rst_dv1", int'(bus1.data_valid), 0);
    chk("rst_empty1", int'(bus1.empty), 1);     chk("rst_level1", int'(bus1.level), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    m_level = 0; m_ovf = 0; m_unf = 0;
    q0.delete(); q1.delete();
    #1;
    reset = 1'b0;
    check_reset_vals();
  endtask

  task automatic check_status0();
    chk("level", int'(bus0.level), m_level);
    chk("full", int'(bus0.full), int'(m_level == 512));
    chk("empty", int'(bus0.empty), int'(m_level == 0));
    chk("almost_full", int'(bus0.almost_full), int'(m_level >= 510));
    chk("almost_empty", int'(bus0.almost_empty), int'(m_level <= 4));
    chk("overflow", int'(bus0.overflow), int'(m_ovf));
    chk("underflow", int'(bus0.underflow), int'(m_unf));
  endtask

  // One cycle of stimulus on the registered-read instance; expected data queued on acceptance
  task automatic step0(input bit w, input logic [7:0] d, input bit r, input bit cf, input bit fl);
    bit rd_ok, wr_ok;
    bus0.write = w; bus0.data_in = d; bus0.read = r; bus0.clear_flags = cf; bus0.flush = fl;
    @(posedge clk);
    if (cf) begin m_ovf = 0; m_unf = 0; end
    if (fl) begin
      m_level = 0;
      q0.delete();
    end else begin
      rd_ok = r && (m_level != 0);
      wr_ok = w && ((m_level != 512) || rd_ok);
      if (wr_ok) q0.push_back(d);
      m_level = m_level + int'(wr_ok) - int'(rd_ok);
      if (w && !wr_ok) m_ovf = 1;
      if (r && !rd_ok) m_unf = 1;
    end
    #1;
    bus0.write = 0; bus0.read = 0; bus0.clear_flags = 0; bus0.flush = 0;
    check_status0();
  endtask

  initial begin
    bus0.write = 0; bus0.data_in = 0; bus0.read = 0; bus0.clear_flags = 0; bus0.flush = 0;
    bus1.write = 0; bus1.data_in = 0; bus1.read = 0; bus1.clear_flags = 0; bus1.flush = 0;
    m_level = 0; m_ovf = 0; m_unf = 0;

    // Reset wins over a concurrent write
    bus0.write = 1; bus0.data_in = 8'hC3;
    repeat (3) @(posedge clk);
    #1;
    bus0.write = 0;
    reset = 1'b0;
    check_reset_vals();

    // FWFT: first word two edges after write, then three pops without bubble
    bus1.write = 1; bus1.data_in = 8'h11;
    @(posedge clk); q1.push_back(8'h11); #1;
    bus1.write = 0;
    chk("fwft_level_n", int'(bus1.level), 1);
    chk("fwft_dv_n", int'(bus1.data_valid), 0);
    chk("fwft_empty_n", int'(bus1.empty), 1);
    @(posedge clk); #1;
    chk("fwft_dv_n1", int'(bus1.data_valid), 0);
    @(posedge clk); #1;
    chk("fwft_dv_n2", int'(bus1.data_valid), 1);
    chk("fwft_dout_n2", int'(bus1.data_out), 8'h11);
    chk("fwft_empty_n2", int'(bus1.empty), 0);
    bus1.write = 1; bus1.data_in = 8'h22;
    @(posedge clk); q1.push_back(8'h22); #1;
    bus1.data_in = 8'h33;
    @(posedge clk); q1.push_back(8'h33); #1;
    bus1.write = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("fwft_level3", int'(bus1.level), 3);
    bus1.read = 1;
    for (int k = 0; k < 3; k++) begin
      chk("fwft_no_bubble", int'(bus1.data_valid), 1);
      @(posedge clk); #1;
    end
    bus1.read = 0;
    chk("fwft_level_end", int'(bus1.level), 0);
    chk("fwft_dv_end", int'(bus1.data_valid), 0);
    chk("fwft_empty_end", int'(bus1.empty), 1);
    bus1.read = 1;
    @(posedge clk); #1;
    bus1.read = 0;
    chk("fwft_underflow", int'(bus1.underflow), 1);
    chk("fwft_level_unf", int'(bus1.level), 0);

    // Write four, read four
    for (int i = 1; i <= 4; i++) step0(1, 8'(i), 0, 0, 0);
    for (int i = 0; i < 4; i++) step0(0, 8'h00, 1, 0, 0);
    repeat (2) step0(0, 8'h00, 0, 0, 0);

    // Read while empty, then read+write at empty, then drain
    step0(0, 8'h00, 1, 0, 0);
    step0(1, 8'h5A, 1, 0, 0);
    step0(0, 8'h00, 0, 1, 0);
    step0(0, 8'h00, 1, 0, 0);
    repeat (2) step0(0, 8'h00, 0, 0, 0);

    // Fill to DEPTH sweeping almost flags, then overflow and clear
    for (int i = 0; i < 512; i++) step0(1, 8'(i), 0, 0, 0);
    step0(1, 8'hEE, 0, 0, 0);
    step0(0, 8'h00, 0, 1, 0);

    // Simultaneous read+write at full, then drain sweeping back down
    repeat (3) step0(1, 8'hAA, 1, 0, 0);
    for (int i = 0; i < 512; i++) step0(0, 8'h00, 1, 0, 0);
    repeat (2) step0(0, 8'h00, 0, 0, 0);

    // Flush at level 300 with a pending write keeps sticky flags
    step0(0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 300; i++) step0(1, 8'(i + 3), 0, 0, 0);
    step0(1, 8'h99, 0, 0, 1);
    step0(1, 8'h42, 0, 0, 0);
    step0(0, 8'h00, 1, 0, 0);
    repeat (2) step0(0, 8'h00, 0, 1, 0);

    // Reset mid-stream with a read in flight; first post-reset write is first read
    step0(1, 8'h10, 0, 0, 0);
    step0(1, 8'h20, 0, 0, 0);
    step0(1, 8'h30, 0, 0, 0);
    step0(0, 8'h00, 1, 0, 0);
    do_reset();
    step0(1, 8'h77, 0, 0, 0);
    step0(0, 8'h00, 1, 0, 0);
    repeat (2) step0(0, 8'h00, 0, 0, 0);

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_gen.md
# fifo_gen

Parametrised synchronous FIFO, the successor to the current byte FIFO. It adds generic width and depth, true simultaneous read/write, and an exact occupancy count. It also adds programmable almost-full/almost-empty thresholds, sticky overflow/underflow flags, a synchronous flush, and an optional first-word-fall-through (FWFT) output mode. It sits between byte/word producers (UART receiver, host bridge) and consumers (CPU load path, transmitters) in the same clock domain, backed by inferred block RAM.

## Interface
- ADDR_WIDTH, 9: capacity is DEPTH = 2^ADDR_WIDTH words.
- DATA_WIDTH, 8: word width.
- AF_LEVEL, DEPTH-4: almost_full asserts when level >= AF_LEVEL. Legal range 1..DEPTH.
- AE_LEVEL, 4: almost_empty asserts when level <= AE_LEVEL. Legal range 0..DEPTH-1.
- FWFT, 0: 0 = standard registered-read mode; 1 = first-word-fall-through.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of contents.
- write  in  1  write request.
- data_in  in  DATA_WIDTH  write data.
- read  in  1  read/pop request.
- data_out  out  DATA_WIDTH  read data.
- data_valid  out  1  data_out holds a valid word (see Operation).
- full  out  1  level == DEPTH.
- empty  out  1  no word available to read.
- almost_full  out  1  level >= AF_LEVEL.
- almost_empty  out  1  level <= AE_LEVEL.
- level  out  ADDR_WIDTH+1  words stored; range 0..DEPTH.
- overflow  out  1  sticky: a write was dropped.
- underflow  out  1  sticky: a read was ignored.
- clear_flags  in  1  clears overflow and underflow.

## Operation
- Reset (reset=1 at an edge), all outputs:
  - data_out = 0, data_valid = 0, full = 0, empty = 1, almost_full = 0, almost_empty = 1, level = 0, overflow = 0, underflow = 0.
  - Read and write pointers are set to 0.
- Reset has priority over everything else.
- RAM contents are not cleared; stale data must never appear with data_valid = 1.
- Flush:
  - Same effect as reset on pointers, level, data_valid, full, empty and the almost flags.
  - overflow and underflow are kept.
  - flush overrides write and read in the same cycle; both are dropped without setting any flag.
- Read acceptance (rd_ok): read = 1 and level != 0, with level sampled before the edge.
- Write acceptance (wr_ok): write = 1 and (level != DEPTH or rd_ok).
  - A write to a full FIFO succeeds when a read is accepted in the same cycle.
- Level update at the edge: level + wr_ok − rd_ok. Simultaneous accepted read and write leave level unchanged.
- Pointers are ADDR_WIDTH wide and wrap modulo DEPTH. They advance by 1 on wr_ok / rd_ok respectively.
- Rejected requests:
  - write while rejected sets overflow.
  - read with level == 0 sets underflow.
  - Both flags hold until clear_flags or reset.
  - If clear_flags and a new error occur in the same cycle, the flag ends set.
- full, empty and the almost flags are registered and are consistent with level after every edge.
  - empty means level == 0 when FWFT=0. When FWFT=1 it means !data_valid.
- FWFT=0:
  - An accepted read at edge N drives the head word on data_out after edge N+1, with data_valid = 1 for exactly that one cycle.
  - data_out holds its value otherwise.
- FWFT=1:
  - The head word is presented on data_out with data_valid = 1 while level != 0.
  - read with data_valid = 1 pops that word. The next word (if any) appears after the following edge with no bubble when level >= 2.
  - level counts the presented word.

## Timing
- Flags and level: 1-cycle latency from the request edge.
- FWFT=0 read latency: 1 cycle (edge after acceptance).
- FWFT=1, write into empty FIFO at edge N: data_valid = 1 after edge N+2; empty deasserts at the same time; level = 1 after edge N.
- Back-to-back reads in FWFT=1 sustain 1 word/cycle.
- Full-rate simultaneous read+write is sustained indefinitely at any level, including 0 (FWFT=0: write accepted, read underflows) and DEPTH (both accepted).
- Reset asserted mid-stream: after that edge, all outputs hold their reset values. The first write accepted after reset deassertion is the first word read.

## Test plan
- Reset, then write 0x01..0x04, then read 4 (FWFT=0) -> data_out 0x01..0x04 on consecutive cycles after each read; level 4→0; empty = 1 at end; no flags set.
- Fill DEPTH=512 words, write once more -> full = 1, level = 512, overflow = 1, and the dropped word is never read back; clear_flags -> overflow = 0.
- At level = 512, assert read+write of 0xAA for 3 cycles -> level stays 512; after draining, the last three words read are 0xAA.
- Read while empty -> underflow = 1, data_valid = 0, level = 0; simultaneous write of 0x5A -> level = 1.
- FWFT=1: write 0x11 at edge N -> data_valid = 1 and data_out = 0x11 after N+2; write 0x22, 0x33, then read ×3 -> 0x11, 0x22, 0x33 with no bubble.
- AF_LEVEL=510, AE_LEVEL=4: sweep level 0→512→0 -> almost flags toggle exactly at 4/5 and 509/510. flush at level 300 with pending write -> level = 0, empty = 1, sticky flags unchanged.
